timer_sched: RTL and testbench
==============================

# timer_sched

Round-robin scheduler that shares one `timer` peripheral between `NREQ` requesters. It arbitrates pending timeout requests and programs the timer's goal register through its APB-style slave port. It then starts the counter, polls the status register until the state field reads COMPLETE, and returns a one-cycle `done` to the winning requester. It sits between client logic and the timer, acting as the timer's only bus master.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `timerbits`, 8, timer data/counter width; equals bus data width
- `addrWidth`, 32, bus address width
- `timerBaseAddr`, 0, base address of the timer register block
- `POLL_GAP`, 2, idle cycles between consecutive status polls (0..15)

- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: asynchronous, active-low reset
- `req` in NREQ: request level; held until matching `done`
- `req_ticks` in NREQ*timerbits: goal per requester, slice i = `[i*timerbits +: timerbits]`
- `done` out NREQ: one-hot, one-cycle completion pulse
- `err` out 1: one-cycle pulse, coincident with `done` when the job failed
- `busy` out 1: high from grant until the `done` cycle inclusive
- `sel`, `enable`, `write` out 1 each: bus master controls
- `addr` out addrWidth: bus address
- `wdata` out timerbits: bus write data
- `rdata` in timerbits: bus read data
- `ready` in 1: slave ready
- `slverr` in 1: slave error, sampled with `ready`

## Operation
- Register map, relative to `timerBaseAddr`:
  - +0 status: bit0 START, bit1 STOP, bits[3:2] state (0 IDLE, 1 RUNNING, 2 COMPLETE)
  - +1 goal
  - +2 current
- Main FSM:
  - IDLE: if any `req` is set, go to ARB.
  - ARB: round-robin grant. Search starts at `last_grant+1`; after reset, requester 0 has top priority. Latch the grant index and its `req_ticks` into `ticks_q`.
    - If `ticks_q == 0`, go to DONE with no bus traffic.
    - Otherwise go to WR_GOAL.
  - WR_GOAL: write `ticks_q` to +1.
  - WR_START: write `8'b0000_0001` to +0.
  - POLL_WAIT: count `POLL_GAP` cycles, then go to POLL_RD.
  - POLL_RD: read +0.
    - `rdata[3:2]==COMPLETE`: go to DONE.
    - RUNNING or IDLE: go to POLL_WAIT.
    - Value 3: treat as an error, go to DONE with `err`.
  - DONE: pulse `done[grant]` (and `err` if flagged), update `last_grant`, return to IDLE.
- Any transfer that completes with `slverr=1` aborts the job immediately: go to DONE with `err=1`.
- A requester dropping `req` after grant does not cancel the job; `done` still pulses.
- `req` still high in the cycle after its `done` is a new request. It loses to other pending requesters under round robin.
- `req_ticks` is sampled only in ARB.

## Timing
- Bus transfer:
  - SETUP cycle: `sel=1`, `enable=0`, `addr`/`write`/`wdata` valid.
  - ACCESS: `sel=1`, `enable=1`, held until `ready=1`.
  - The next cycle returns to `sel=0`, `enable=0`.
- `addr`, `write` and `wdata` stay stable from SETUP through the last ACCESS cycle. `rdata`/`slverr` are captured in the `ready` cycle.
- Minimum job with zero-wait slave and `POLL_GAP=0`: ARB 1 cycle, two writes at 3 cycles each, each poll 3 cycles, DONE 1 cycle.
- Zero-tick job: `done` in the cycle after ARB.
- Reset (asynchronous, mid-transfer included) forces the following; the FSM restarts in IDLE and the job is lost:
  - `sel`, `enable`, `write` = 0
  - `addr`, `wdata` = 0
  - `done`, `err`, `busy` = 0
  - `last_grant = NREQ-1`

## Configuration
- `TIMER_SCHED_WATCHDOG_EN` defined:
  - A poll counter aborts the job after `2^timerbits + 4` consecutive non-COMPLETE polls.
  - On abort, write `8'b0000_0011` (START|STOP) to +0, then go to DONE with `err=1`.
- Not defined: poll indefinitely, with no counter logic.

## Structure
- Package `timer_pkg`: address offsets, STATUS bit positions, `CTR_STATE_LEN`, the `e_ctr_state` enum, and the `e_rw` enum. The `timer` block imports the same package.
- One sub-module, `timer_apb_xfer`: a single-transfer bus engine.
  - Inputs: `start`, `rw`, `addr`, `wdata`.
  - Outputs: `busy`, a one-cycle `xfer_done`, `rdata_q`, `err_q`.
- `timer_sched` holds only arbitration, the job FSM and the poll/watchdog counters.

## Test plan
- Single requester 0, `ticks=25`, real `timer` as slave:
  - Bus sequence: write +1 = 25, then write +0 = 1, then reads of +0.
  - `done[0]` fires only after a read returns state 2. No transfer starts while `sel=0`.
- Requesters 1 and 3 raise `req` in the same cycle, `ticks` 5 and 7: 1 is served before 3; then 3 is served before 1 re-requesting.
- `ticks=0` on requester 2: `done[2]` pulses 2 cycles after `req`, with zero `sel` activity.
- Slave model with 3 wait states and `slverr=1` on the goal write: `done`+`err` pulse, no start write is issued, `busy` drops.
- Assert `reset` mid-ACCESS of a poll: outputs are 0 asynchronously. After release, a pending `req` restarts cleanly from WR_GOAL.
- With `TIMER_SCHED_WATCHDOG_EN` and a slave that always returns RUNNING: after 260 polls, write +0 = 3, then `err=1`.

Source files
------------

// File: rtl/timer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : timer_pkg                                                    |
// | Description : Shared register map, STATUS field layout and enums for the   |
// |               timer peripheral and its bus masters (timer, timer_sched).   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package timer_pkg;

  // Register offsets relative to the timer base address
  localparam int TIMER_OFS_STATUS  = 0;
  localparam int TIMER_OFS_GOAL    = 1;
  localparam int TIMER_OFS_CURRENT = 2;

  // STATUS register bit positions
  localparam int TIMER_STATUS_START     = 0;
  localparam int TIMER_STATUS_STOP      = 1;
  localparam int TIMER_STATUS_STATE_LSB = 2;

  // Width of the STATUS state field
  localparam int CTR_STATE_LEN = 2;

  typedef enum logic [CTR_STATE_LEN-1:0] {
    CTR_IDLE     = 2'd0,
    CTR_RUNNING  = 2'd1,
    CTR_COMPLETE = 2'd2
  } e_ctr_state;

  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } e_rw;

endpackage
`default_nettype wire

// File: rtl/timer_apb_xfer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : timer_apb_xfer                                               |
// | Description : Single-transfer APB-style bus master. A start pulse while    |
// |               idle launches one SETUP/ACCESS transfer; xfer_done pulses    |
// |               in the cycle after the ready cycle, with rdata_q/err_q valid.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, reset(active-low, async)                                            |
// |   start, rw, addr, wdata     : transfer request (accepted only when idle)  |
// |   busy, xfer_done            : engine status / one-cycle completion        |
// |   rdata_q, err_q             : data and slave error captured with ready    |
// |   bus_*                      : bus master signals toward the slave         |
// +----------------------------------------------------------------------------+
module timer_apb_xfer
  import timer_pkg::*;
#(
  parameter int addrWidth = 32,
  parameter int dataWidth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  e_rw                  rw,
  input  logic [addrWidth-1:0] addr,
  input  logic [dataWidth-1:0] wdata,
  output logic                 busy,
  output logic                 xfer_done,
  output logic [dataWidth-1:0] rdata_q,
  output logic                 err_q,
  output logic                 bus_sel,
  output logic                 bus_enable,
  output logic                 bus_write,
  output logic [addrWidth-1:0] bus_addr,
  output logic [dataWidth-1:0] bus_wdata,
  input  logic [dataWidth-1:0] bus_rdata,
  input  logic                 bus_ready,
  input  logic                 bus_slverr
);

  typedef enum logic [1:0] {
    X_IDLE   = 2'd0,
    X_SETUP  = 2'd1,
    X_ACCESS = 2'd2
  } e_xfer_phase;

  e_xfer_phase          phase_q, phase_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic [dataWidth-1:0] wdata_q, wdata_d;
  logic                 write_q, write_d;
  logic [dataWidth-1:0] rdata_d;
  logic                 err_d;
  logic                 done_q, done_d;

  always_comb begin
    phase_d = phase_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (phase_q)
      X_IDLE: begin
        // Request fields are captured here so they stay stable for the
        // whole transfer regardless of what the requester does afterwards.
        if (start) begin
          phase_d = X_SETUP;
          addr_d  = addr;
          wdata_d = wdata;
          write_d = (rw == RW_WRITE);
        end
      end
      X_SETUP: phase_d = X_ACCESS;
      X_ACCESS: begin
        if (bus_ready) begin
          phase_d = X_IDLE;
          done_d  = 1'b1;
          rdata_d = bus_rdata;
          err_d   = bus_slverr;
        end
      end
      default: phase_d = X_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= X_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy       = (phase_q != X_IDLE);
  assign xfer_done  = done_q;
  assign bus_sel    = (phase_q != X_IDLE);
  assign bus_enable = (phase_q == X_ACCESS);
  assign bus_write  = write_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;

endmodule
`default_nettype wire

// File: rtl/timer_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : timer_sched                                                  |
// | Description : Round-robin scheduler sharing one timer peripheral among     |
// |               NREQ requesters. Programs goal, starts the counter, polls    |
// |               STATUS until COMPLETE and pulses done[grant] (err on fault). |
// | Config      : TIMER_SCHED_WATCHDOG_EN - abort after 2^timerbits+4          |
// |               consecutive non-COMPLETE polls (writes START|STOP, err=1).   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, reset(active-low, async)                                            |
// |   req[NREQ], req_ticks[NREQ*timerbits] : requests and per-requester goals  |
// |   done[NREQ], err, busy                : completion / error / job active   |
// |   sel, enable, write, addr, wdata      : bus master outputs                |
// |   rdata, ready, slverr                 : bus slave responses               |
// +----------------------------------------------------------------------------+
module timer_sched
  import timer_pkg::*;
#(
  parameter int                   NREQ          = 4,
  parameter int                   timerbits     = 8,
  parameter int                   addrWidth     = 32,
  parameter logic [addrWidth-1:0] timerBaseAddr = '0,
  parameter int                   POLL_GAP      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*timerbits-1:0] req_ticks,
  output logic [NREQ-1:0]           done,
  output logic                      err,
  output logic                      busy,
  output logic                      sel,
  output logic                      enable,
  output logic                      write,
  output logic [addrWidth-1:0]      addr,
  output logic [timerbits-1:0]      wdata,
  input  logic [timerbits-1:0]      rdata,
  input  logic                      ready,
  input  logic                      slverr
);

  localparam int GW = $clog2(NREQ);
  localparam logic [addrWidth-1:0] ADDR_STATUS = timerBaseAddr + addrWidth'(TIMER_OFS_STATUS);
  localparam logic [addrWidth-1:0] ADDR_GOAL   = timerBaseAddr + addrWidth'(TIMER_OFS_GOAL);
  localparam logic [timerbits-1:0] WDATA_START = timerbits'(1 << TIMER_STATUS_START);
  localparam logic [3:0]           GAP_LAST    = 4'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
`ifdef TIMER_SCHED_WATCHDOG_EN
  localparam logic [timerbits-1:0] WDATA_STOP  =
    timerbits'((1 << TIMER_STATUS_START) | (1 << TIMER_STATUS_STOP));
  localparam int                   WDW         = timerbits + 2;
  localparam logic [WDW-1:0]       WD_LAST     = WDW'((1 << timerbits) + 3);
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_WR_GOAL   = 3'd2,
    S_WR_START  = 3'd3,
    S_POLL_WAIT = 3'd4,
    S_POLL_RD   = 3'd5,
    S_WD_STOP   = 3'd6,
    S_DONE      = 3'd7
  } e_sched_state;

  e_sched_state   state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  last_grant_q, last_grant_d;
  logic           job_err_q, job_err_d;
  logic [3:0]     gap_cnt_q, gap_cnt_d;
`ifdef TIMER_SCHED_WATCHDOG_EN
  logic [WDW-1:0] poll_cnt_q, poll_cnt_d;
`endif

  // Transfer engine request/response
  logic                 x_start;
  e_rw                  x_rw;
  logic [addrWidth-1:0] x_addr;
  logic [timerbits-1:0] x_wdata;
  logic                 x_busy;
  logic                 x_done;
  logic [timerbits-1:0] x_rdata;
  logic                 x_err;

  logic                     enter_poll;
  logic                     issue_poll;
  logic                     arb_found;
  logic [GW-1:0]            arb_idx;
  logic [timerbits-1:0]     arb_ticks;
  logic [timerbits-1:0]     ticks_arr [NREQ];
  logic [CTR_STATE_LEN-1:0] poll_state;
  logic                     unused_rdata_bits;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ticks_unpack
    assign ticks_arr[gi] = req_ticks[gi*timerbits +: timerbits];
  end

  assign poll_state        = x_rdata[TIMER_STATUS_STATE_LSB +: CTR_STATE_LEN];
  assign unused_rdata_bits = ^x_rdata;

  // Round robin: scan from last_grant+1 upward, wrapping, first hit wins.
  always_comb begin
    int cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!arb_found && req[GW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = GW'(cand);
      end
    end
  end

  assign arb_ticks = ticks_arr[arb_idx];

  // Each bus state is entered together with the engine start pulse, so the
  // transfer's SETUP cycle is the first cycle spent in that state and the
  // state is left in the xfer_done cycle (3 cycles per zero-wait transfer).
  // The engine's write-data register holds the latched goal for the job.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    job_err_d    = job_err_q;
    gap_cnt_d    = gap_cnt_q;
`ifdef TIMER_SCHED_WATCHDOG_EN
    poll_cnt_d   = poll_cnt_q;
`endif
    x_start      = 1'b0;
    x_rw         = RW_WRITE;
    x_addr       = ADDR_GOAL;
    x_wdata      = arb_ticks;
    enter_poll   = 1'b0;
    issue_poll   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|req) state_d = S_ARB;
      end
      S_ARB: begin
        if (!arb_found) begin
          state_d = S_IDLE;
        end else begin
          grant_d   = arb_idx;
          job_err_d = 1'b0;
`ifdef TIMER_SCHED_WATCHDOG_EN
          poll_cnt_d = '0;
`endif
          if (arb_ticks == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WR_GOAL;
            x_start = 1'b1;
          end
        end
      end
      S_WR_GOAL: begin
        if (x_done) begin
          if (x_err) begin
            job_err_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            state_d = S_WR_START;
            x_start = 1'b1;
            x_addr  = ADDR_STATUS;
            x_wdata = WDATA_START;
          end
        end
      end
      S_WR_START: begin
        if (x_done) begin
          if (x_err) begin
            job_err_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            enter_poll = 1'b1;
          end
        end
      end
      S_POLL_WAIT: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (!x_busy) issue_poll = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      S_POLL_RD: begin
        if (x_done) begin
          if (x_err) begin
            job_err_d = 1'b1;
            state_d   = S_DONE;
          end else if (poll_state == CTR_COMPLETE) begin
            state_d = S_DONE;
          end else if (poll_state == CTR_STATE_LEN'(3)) begin
            // Undefined state encoding: report the job as failed
            job_err_d = 1'b1;
            state_d   = S_DONE;
          end else begin
`ifdef TIMER_SCHED_WATCHDOG_EN
            poll_cnt_d = poll_cnt_q + 1'b1;
            if (poll_cnt_q == WD_LAST) begin
              state_d = S_WD_STOP;
              x_start = 1'b1;
              x_addr  = ADDR_STATUS;
              x_wdata = WDATA_STOP;
            end else begin
              enter_poll = 1'b1;
            end
`else
            enter_poll = 1'b1;
`endif
          end
        end
      end
`ifdef TIMER_SCHED_WATCHDOG_EN
      S_WD_STOP: begin
        if (x_done) begin
          job_err_d = 1'b1;
          state_d   = S_DONE;
        end
      end
`endif
      S_DONE: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // With no gap configured the status read is issued back-to-back.
    if (enter_poll) begin
      if (POLL_GAP == 0) begin
        issue_poll = 1'b1;
      end else begin
        state_d   = S_POLL_WAIT;
        gap_cnt_d = '0;
      end
    end
    if (issue_poll) begin
      state_d = S_POLL_RD;
      x_start = 1'b1;
      x_rw    = RW_READ;
      x_addr  = ADDR_STATUS;
      x_wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NREQ - 1);
      job_err_q    <= 1'b0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      job_err_q    <= job_err_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

`ifdef TIMER_SCHED_WATCHDOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) poll_cnt_q <= '0;
    else        poll_cnt_q <= poll_cnt_d;
  end
`endif

  assign done = (state_q == S_DONE) ? (NREQ'(1) << grant_q) : '0;
  assign err  = (state_q == S_DONE) && job_err_q;
  assign busy = (state_q != S_IDLE);

  timer_apb_xfer #(
    .addrWidth (addrWidth),
    .dataWidth (timerbits)
  ) u_xfer (
    .clk        (clk),
    .reset      (reset),
    .start      (x_start),
    .rw         (x_rw),
    .addr       (x_addr),
    .wdata      (x_wdata),
    .busy       (x_busy),
    .xfer_done  (x_done),
    .rdata_q    (x_rdata),
    .err_q      (x_err),
    .bus_sel    (sel),
    .bus_enable (enable),
    .bus_write  (write),
    .bus_addr   (addr),
    .bus_wdata  (wdata),
    .bus_rdata  (rdata),
    .bus_ready  (ready),
    .bus_slverr (slverr)
  );

endmodule
`default_nettype wire

// File: tb/tb_timer_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_timer_sched                                               |
// | Description : Directed self-checking bench for timer_sched with a small    |
// |               timer slave model, transfer log and bus protocol monitor.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_timer_sched;

  localparam int NREQ = 4;
  localparam int TB   = 8;
  localparam int LOGN = 2048;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ*TB-1:0] req_ticks = '0;
  logic [NREQ-1:0]  done;
  logic             err, busy, sel, enable, write;
  logic [31:0]      addr;
  logic [TB-1:0]    wdata, rdata;
  logic             ready, slverr;

  timer_sched dut (
    .clk(clk), .reset(reset), .req(req), .req_ticks(req_ticks),
    .done(done), .err(err), .busy(busy),
    .sel(sel), .enable(enable), .write(write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .slverr(slverr)
  );

  always #5 clk = ~clk;

  // ---------------- timer slave model ----------------
  int         waits = 0;
  int         wcnt = 0;
  bit         err_on_goal = 1'b0;
  bit         force_running = 1'b0;
  logic [1:0] tm_st = 2'd0;
  logic [7:0] tm_goal = 8'd0;
  logic [7:0] tm_cur = 8'd0;

  assign ready  = sel && enable && (wcnt >= waits);
  assign slverr = ready && err_on_goal && write && (addr == 32'd1);
  assign rdata  = (addr == 32'd0) ? {4'b0000, (force_running ? 2'd1 : tm_st), 2'b00} :
                  (addr == 32'd1) ? tm_goal : tm_cur;

  logic [31:0] lg_addr  [LOGN];
  logic        lg_write [LOGN];
  logic [7:0]  lg_data  [LOGN];
  int          n_xfer = 0;

  always @(posedge clk) begin
    if (sel && enable && !ready) wcnt <= wcnt + 1;
    else                         wcnt <= 0;
    if (tm_st == 2'd1) begin
      tm_cur <= tm_cur + 8'd1;
      if (tm_cur + 8'd1 >= tm_goal) tm_st <= 2'd2;
    end
    if (ready && write && !slverr) begin
      if (addr == 32'd1) tm_goal <= wdata;
      else if (addr == 32'd0 && wdata[0]) begin
        tm_st  <= 2'd1;
        tm_cur <= 8'd0;
      end
    end
    if (ready && n_xfer < LOGN) begin
      lg_addr[n_xfer]  <= addr;
      lg_write[n_xfer] <= write;
      lg_data[n_xfer]  <= write ? wdata : rdata;
      n_xfer           <= n_xfer + 1;
    end
  end

  // ---------------- cycle counter and protocol monitor ----------------
  int          cyc = 0;
  int          viol = 0;
  int          sel_cnt = 0;
  logic        p_sel = 1'b0, p_en = 1'b0, p_rdy = 1'b0, p_wr = 1'b0;
  logic [31:0] p_addr = '0;
  logic [7:0]  p_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      p_sel = 1'b0; p_en = 1'b0; p_rdy = 1'b0;
    end else begin
      if (sel) sel_cnt++;
      if (enable && !sel) viol++;
      if (enable && !p_sel) viol++;
      if (sel && p_sel && p_en && p_rdy) viol++;
      if (sel && p_sel && !(p_en && p_rdy) &&
          (addr != p_addr || write != p_wr || wdata != p_wdata)) viol++;
      p_sel = sel; p_en = enable; p_rdy = ready; p_wr = write;
      p_addr = addr; p_wdata = wdata;
    end
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int done_cyc = 0;

  task automatic wait_done(input int budget, output logic [NREQ-1:0] d, output logic e);
    bit seen;
    seen = 1'b0;
    d = '0;
    e = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (|done) begin
        seen = 1'b1;
        d = done;
        e = err;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic set_ticks(input int idx, input logic [7:0] v);
    req_ticks[idx*TB +: TB] = v;
  endtask

  // ---------------- directed sequence ----------------
  logic [NREQ-1:0] d;
  logic            e;
  int              base, n_bad, n_complete, c0, s0;
  bit              found;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_bus_ctl", {29'd0, sel, enable, write}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_wdata", {24'd0, wdata}, 32'd0);
    check("rst_outputs", {25'd0, done, err, busy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single requester 0, 25 ticks
    base = n_xfer;
    set_ticks(0, 8'd25);
    req = 4'b0001;
    wait_done(3000, d, e);
    req = 4'b0000;
    check("t1_done", {28'd0, d}, 32'h1);
    check("t1_err", {31'd0, e}, 32'd0);
    check("t1_goal_wr", {lg_write[base], lg_addr[base][7:0], lg_data[base]}, {1'b1, 8'd1, 8'd25});
    check("t1_start_wr", {lg_write[base+1], lg_addr[base+1][7:0], lg_data[base+1]}, {1'b1, 8'd0, 8'd1});
    n_bad = 0;
    n_complete = 0;
    for (int i = base + 2; i < n_xfer; i++) begin
      if (lg_write[i] || lg_addr[i] != 32'd0) n_bad++;
      if (lg_data[i][3:2] == 2'd2) n_complete++;
    end
    check("t1_polls_status_reads", n_bad, 0);
    check("t1_complete_reads", n_complete, 1);
    check("t1_last_read_state", {30'd0, lg_data[n_xfer-1][3:2]}, 32'd2);
    @(negedge clk);
    check("t1_busy_drop", {31'd0, busy}, 32'd0);

    // Requesters 1 and 3 together; 1 re-requests after its done
    set_ticks(1, 8'd5);
    set_ticks(3, 8'd7);
    base = n_xfer;
    req = 4'b1010;
    wait_done(3000, d, e);
    check("t2_first", {28'd0, d}, 32'h2);
    check("t2_first_goal", {24'd0, lg_data[base]}, 32'd5);
    base = n_xfer;
    wait_done(3000, d, e);
    req[3] = 1'b0;
    check("t2_second", {28'd0, d}, 32'h8);
    check("t2_second_goal", {24'd0, lg_data[base]}, 32'd7);
    wait_done(3000, d, e);
    req[1] = 1'b0;
    check("t2_third", {28'd0, d}, 32'h2);
    @(negedge clk);

    // Zero-tick job on requester 2
    set_ticks(2, 8'd0);
    c0 = cyc;
    s0 = sel_cnt;
    req = 4'b0100;
    wait_done(50, d, e);
    req = 4'b0000;
    check("t3_done", {28'd0, d}, 32'h4);
    check("t3_err", {31'd0, e}, 32'd0);
    check("t3_latency", done_cyc - c0, 2);
    check("t3_no_bus", sel_cnt - s0, 0);
    @(negedge clk);

    // slverr on the goal write with 3 wait states
    waits = 3;
    err_on_goal = 1'b1;
    set_ticks(0, 8'd9);
    base = n_xfer;
    req = 4'b0001;
    wait_done(3000, d, e);
    req = 4'b0000;
    check("t4_done", {28'd0, d}, 32'h1);
    check("t4_err", {31'd0, e}, 32'd1);
    check("t4_xfers", n_xfer - base, 1);
    @(negedge clk);
    check("t4_busy_drop", {31'd0, busy}, 32'd0);
    err_on_goal = 1'b0;

    // Reset in the ACCESS phase of a status poll
    set_ticks(0, 8'd50);
    req = 4'b0001;
    found = 1'b0;
    for (int n = 0; n < 500 && !found; n++) begin
      @(negedge clk);
      if (sel && enable && !write) found = 1'b1;
    end
    check("t5_reached_poll", {31'd0, found}, 32'd1);
    set_ticks(3, 8'd3);
    req = 4'b1001;
    reset = 1'b0;
    #1;
    check("t5_async_bus", {29'd0, sel, enable, write}, 32'd0);
    check("t5_async_addr", addr, 32'd0);
    check("t5_async_out", {25'd0, done, err, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    base = n_xfer;
    wait_done(3000, d, e);
    req[0] = 1'b0;
    check("t5_restart_grant", {28'd0, d}, 32'h1);
    check("t5_restart_goal", {lg_write[base], lg_addr[base][7:0], lg_data[base]}, {1'b1, 8'd1, 8'd50});
    wait_done(3000, d, e);
    req = 4'b0000;
    check("t5_then_req3", {28'd0, d}, 32'h8);
    @(negedge clk);

`ifdef TIMER_SCHED_WATCHDOG_EN
    // Slave stuck in RUNNING: abort after 260 polls
    waits = 0;
    force_running = 1'b1;
    set_ticks(0, 8'd5);
    base = n_xfer;
    req = 4'b0001;
    wait_done(5000, d, e);
    req = 4'b0000;
    check("wd_done", {28'd0, d}, 32'h1);
    check("wd_err", {31'd0, e}, 32'd1);
    n_bad = 0;
    for (int i = base; i < n_xfer; i++) if (!lg_write[i]) n_bad++;
    check("wd_poll_count", n_bad, 260);
    check("wd_stop_wr", {lg_write[n_xfer-1], lg_addr[n_xfer-1][7:0], lg_data[n_xfer-1]}, {1'b1, 8'd0, 8'd3});
    force_running = 1'b0;
    @(negedge clk);
`endif

    check("bus_protocol", viol, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
